// File: rtl/alu_sequencer.sv
// Command sequencer for an external combinational ALU: reads operands from a local
// register file, issues A/B/Sel, captures C, writes it back and returns it to the caller.
module alu_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned AW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [AW-1:0]     cmd_rd,
    input  logic [AW-1:0]     cmd_rs1,
    input  logic [AW-1:0]     cmd_rs2,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_c,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [AW-1:0]     res_rd,
    output logic              res_err,
    output logic              busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam logic [3:0] LAST_VALID_OP = 4'd9;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [DATA_W-1:0] rf [NREGS];
    logic              load_fire;
    logic              cmd_fire;
    logic              op_bad;

    // Loads take priority over commands while idle; nothing is accepted otherwise.
    assign load_ready = (state == IDLE);
    assign cmd_ready  = (state == IDLE) && !load_valid;
    assign load_fire  = load_valid && load_ready;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign op_bad     = (alu_sel > LAST_VALID_OP);
    assign res_valid  = (state == RESP);
    assign busy       = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; ISSUE always lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Register file: preload writes in IDLE, result writeback at the end of ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (load_fire) begin
            rf[load_addr] <= load_data;
        end else if ((state == ISSUE) && !op_bad) begin
            rf[res_rd] <= alu_c;
        end
    end

    // Operand/select registers hold the last issued command until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            res_rd  <= '0;
        end else if (cmd_fire) begin
            alu_a   <= rf[cmd_rs1];
            alu_b   <= rf[cmd_rs2];
            alu_sel <= cmd_op;
            res_rd  <= cmd_rd;
        end
    end

    // Result capture; unsupported selects return zero with the error flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data <= '0;
            res_err  <= 1'b0;
        end else if (state == ISSUE) begin
            res_data <= op_bad ? '0 : alu_c;
            res_err  <= op_bad;
        end
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator side of the shared ALU operand/select interface (A, B, 4-bit Sel in; 32-bit C out, combinational).
- Accepts register-to-register commands over a valid/ready handshake and reads operands from an internal register file.
- Drives registered A/B/Sel to an external ALU, captures C one cycle later, writes it back and returns it over a second valid/ready handshake.
- Sits between the control front end and the existing combinational ALU.

Parameters:
- DATA_W, 32, operand/result width; must match ALU width.
- NREGS, 8, register-file depth.
- AW, 3, register address width; NREGS = 2**AW.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  register preload request.
- load_ready  output  1  preload accepted this cycle.
- load_addr  input  AW  preload target register.
- load_data  input  DATA_W  preload value.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted this cycle.
- cmd_op  input  4  ALU select code.
- cmd_rd  input  AW  destination register.
- cmd_rs1  input  AW  source register for A.
- cmd_rs2  input  AW  source register for B.
- alu_a  output  DATA_W  operand A to ALU.
- alu_b  output  DATA_W  operand B to ALU.
- alu_sel  output  4  select to ALU.
- alu_c  input  DATA_W  ALU result (combinational from alu_a/alu_b/alu_sel).
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes result.
- res_data  output  DATA_W  captured result.
- res_rd  output  AW  destination register of the result.
- res_err  output  1  op code was unsupported.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst=1): FSM=IDLE; all register-file entries 0; alu_a/alu_b/alu_sel/res_data/res_rd 0; res_valid/res_err 0. Reset mid-operation aborts with no writeback and no response.
- ALU op encoding:
  - 0 add; 1 sub; 2 and; 3 or; 4 xor.
  - 5 eq; 6 unsigned gt; 7 unsigned lt; compares return 0 or 1, zero-extended.
  - 8 logical shift right by B; 9 shift left by B.
  - 10-15 unsupported.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - load_ready = 1 and cmd_ready = !load_valid. Loads have priority; on a simultaneous load and cmd, only the load is taken.
  - Load handshake: rf[load_addr] <= load_data; stays in IDLE.
  - Cmd handshake: alu_a <= rf[rs1], alu_b <= rf[rs2], alu_sel <= cmd_op, res_rd <= cmd_rd; go to ISSUE. A load and a read of the same register in one cycle cannot happen, because the load blocks the cmd.
- ISSUE (exactly 1 cycle): at the closing edge res_data <= alu_c; res_err <= (alu_sel > 9).
  - If the op is valid, rf[res_rd] <= alu_c. If invalid, res_data <= 0 and there is no writeback.
  - Go to RESP.
- RESP: res_valid = 1. res_data, res_rd and res_err hold stable until res_ready. On res_ready go to IDLE (res_valid is 0 next cycle).
  - load_ready = cmd_ready = 0 in ISSUE and RESP.
  - alu_a/alu_b/alu_sel hold their last issued values until the next command.
- Latency: cmd accept edge N → res_valid high from cycle N+2. Minimum throughput is one command per 3 cycles with res_ready tied high.
- rd may equal rs1/rs2; operands come from the pre-command values.
- No register is hardwired to zero.
- busy = (state != IDLE).
- Width rules:
  - Add/sub wrap modulo 2**DATA_W with no carry out.
  - Shift amounts are the full B value; B >= DATA_W yields 0 per ALU semantics.

Test Plan:
- Reset then preload r1=5, r2=3; cmd op=0 rd=3 rs1=1 rs2=2 → alu_a=5, alu_b=3, alu_sel=0 one cycle after accept; res_valid at N+2 with res_data=8, res_rd=3, res_err=0; next cmd reads r3=8.
- r1=0x00000000, r2=1, op=1 → res_data=0xFFFFFFFF (wrap); op=6 with r1=7, r2=7 → 0; op=5 → 1.
- op=12 → res_valid with res_err=1, res_data=0, destination register unchanged.
- Hold res_ready=0 for 5 cycles in RESP → res_valid, res_data and res_rd stable; cmd_ready=0 and load_ready=0 throughout; one cycle after res_ready=1, cmd_ready=1.
- In IDLE, assert load_valid and cmd_valid together → load written, cmd_ready=0; the cmd is accepted on the next cycle after load_valid drops.
- Assert rst during ISSUE after cmd rd=4 → res_valid never rises; r4=0; all outputs 0 asynchronously.
